mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline memory stage sitting directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and resolves branches from the ALU zero flag.
- Runs a request/acknowledge handshake to a variable-latency data memory.
- Presents a registered MEM/WB bundle to writeback, and stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT, 16: max cycles in ACCESS without dmem_ack before the bus error abort; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous, active-high reset; the port name is kept for consistency with the other stages.
- iValid  in  1  execute stage presents a valid instruction.
- iSig_MemRead  in  1  load.
- iSig_MemWrite  in  1  store.
- iSig_Branch  in  1  beq-type branch.
- iSig_RegWrite  in  1  instruction writes the register file.
- iSig_MemtoReg  in  1  writeback selects memory data.
- iadder_branch_result  in  32  branch target from execute.
- iALU_zero  in  1  ALU zero flag.
- iALU_result  in  32  ALU result; also the memory address.
- iregfile_read_2  in  32  store data.
- ireg_write_reg  in  5  destination register.
- oStall  out  1  upstream must hold its outputs.
- oPCSrc  out  1  branch taken.
- obranch_target  out  32  target PC, valid when oPCSrc=1.
- odmem_req  out  1  memory request.
- odmem_we  out  1  1=write, 0=read.
- odmem_addr  out  32  word address.
- odmem_wdata  out  32  store data.
- idmem_ack  in  1  access complete this cycle.
- idmem_rdata  in  32  read data, valid with idmem_ack.
- oWB_valid  out  1  MEM/WB bundle valid.
- oWB_RegWrite  out  1  gated RegWrite.
- oWB_MemtoReg  out  1  MemtoReg.
- oWB_read_data  out  32  loaded word.
- oWB_ALU_result  out  32  ALU result.
- oWB_write_reg  out  5  destination register.
- oMisaligned  out  1  sticky: memory op with addr[1:0]!=0.
- oBusErr  out  1  sticky: timeout abort.

Behaviour:
- Reset:
  - All EX/MEM and MEM/WB registers, oWB_*, oMisaligned, oBusErr and the timeout counter clear to 0.
  - State goes to IDLE.
  - Reset mid-access drops odmem_req in the following cycle and discards the op.
- Capture: EX/MEM loads all i* fields on an edge where iValid=1 and oStall=0. Otherwise em_valid clears, unless the block is stalling, in which case em_valid holds.
- FSM states are IDLE and ACCESS.
- IDLE:
  - Non-memory op (em_valid=1, no MemRead/MemWrite): MEM/WB loads at the next edge. Total latency is 2 edges from iValid acceptance.
  - Memory op with em_addr[1:0]==0: go to ACCESS, counter=0.
  - Memory op with em_addr[1:0]!=0: no access, set oMisaligned, retire with oWB_RegWrite=0.
- ACCESS:
  - odmem_req=1, with odmem_we, odmem_addr and odmem_wdata driven from EX/MEM and held stable until ack.
  - oStall = (state==ACCESS) & ~idmem_ack.
  - On idmem_ack: MEM/WB loads with read data = idmem_rdata (loads) or 0 (stores); go to IDLE.
  - A new op may be captured on the ack edge (back-to-back allowed).
  - If the counter reaches TIMEOUT-1 with no ack: abort, set oBusErr, retire with oWB_RegWrite=0, go to IDLE. A late ack arriving in IDLE is ignored.
- oWB_valid is a 1-cycle pulse per retired op, never asserted for bubbles.
- MEM/WB fields other than oWB_valid hold their last value between pulses.
- Stores always retire with oWB_RegWrite=0, regardless of the input.
- Branch:
  - oPCSrc = em_valid & em_Branch & em_zero, combinational from EX/MEM.
  - obranch_target = em_branch_target.
  - A branch op is never a memory op; asserting iSig_Branch together with MemRead/MemWrite is illegal, and the bench flags it with an assertion.
- odmem_req is never asserted in IDLE.
- Exactly one request is issued per memory op.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE=0, ST_ACCESS=1);
  - the EX/MEM field widths (32 data, 5 reg index);
  - the word-alignment mask constant 2'b00.
- One sub-module: dmem_handshake, containing the FSM, timeout counter and odmem_* drive. It returns done/abort to the stage; the register banks stay in mem_stage.

Test Plan:
- ALU op with iALU_result=0x0000_0010, RegWrite=1, ireg_write_reg=5 → 2 edges later oWB_valid=1, oWB_ALU_result=0x10, oWB_write_reg=5, odmem_req never asserted.
- Load at addr 0x40, ack after 3 cycles with rdata 0xDEADBEEF:
  - odmem_req=1, we=0, addr=0x40 held for 3 cycles, oStall=1 for 2 cycles;
  - oWB_read_data=0xDEADBEEF, oWB_RegWrite=1.
- Store to 0x44, data 0x1234 immediately followed by a load: single-cycle ack on the store; the load is captured on the ack edge; two requests; store retires with oWB_RegWrite=0.
- Load at addr 0x42 → no request, oMisaligned=1 (sticky), oWB_valid=1 with oWB_RegWrite=0.
- TIMEOUT=4, load with no ack → req held 4 cycles then dropped, oBusErr=1, oStall returns 0; late ack ignored.
- Branch with iALU_zero=1, target 0x100 → oPCSrc=1 for exactly one cycle with obranch_target=0x100.
- Same branch with zero=0 → oPCSrc stays 0.
- rstn mid-ACCESS → outputs zero next edge, no oWB_valid.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage.
// Imported by the stage, its handshake and the dmem interface.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [1:0] WORD_ALIGN = 2'b00;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              reg_write;
    logic              mem_to_reg;
    logic              zero;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
  } ex_mem_t;

  function automatic logic is_aligned(
    input logic [DATA_W-1:0] a
  );
    return a[1:0] == WORD_ALIGN;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge bus between the memory stage
// and a variable-latency data memory.
interface mem_stage_if
  import mem_stage_pkg::*;
();

  logic              odmem_req;
  logic              odmem_we;
  logic [DATA_W-1:0] odmem_addr;
  logic [DATA_W-1:0] odmem_wdata;
  logic              idmem_ack;
  logic [DATA_W-1:0] idmem_rdata;

  modport master (
    output odmem_req,
    output odmem_we,
    output odmem_addr,
    output odmem_wdata,
    input  idmem_ack,
    input  idmem_rdata
  );

  modport slave (
    input  odmem_req,
    input  odmem_we,
    input  odmem_addr,
    input  odmem_wdata,
    output idmem_ack,
    output idmem_rdata
  );

endinterface

// File: rtl/dmem_handshake.sv
// IDLE/ACCESS sequencer for the data memory bus with a
// bounded wait; reports done/abort back to the stage.
module dmem_handshake
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              abort,
  output logic              stall,
  mem_stage_if.master       dmem
);

  logic [0:0] state;
  logic [7:0] cnt;
  logic       busy;

  assign busy  = state == ST_ACCESS;
  assign done  = busy & dmem.idmem_ack;
  assign stall = busy & ~dmem.idmem_ack;
  assign abort = stall
               & (cnt == 8'(TIMEOUT - 1));

  // Bus fields come straight from EX/MEM, which is
  // frozen by the stall until the ack edge.
  assign dmem.odmem_req   = busy;
  assign dmem.odmem_we    = we;
  assign dmem.odmem_addr  = addr;
  assign dmem.odmem_wdata = wdata;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (start) begin
      state <= ST_ACCESS;
      cnt   <= '0;
    end else if (done | abort) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (busy) begin
      cnt   <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, branch resolve,
// data memory access and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iValid,
  input  logic              iSig_MemRead,
  input  logic              iSig_MemWrite,
  input  logic              iSig_Branch,
  input  logic              iSig_RegWrite,
  input  logic              iSig_MemtoReg,
  input  logic [DATA_W-1:0] iadder_branch_result,
  input  logic              iALU_zero,
  input  logic [DATA_W-1:0] iALU_result,
  input  logic [DATA_W-1:0] iregfile_read_2,
  input  logic [REG_W-1:0]  ireg_write_reg,
  output logic              oStall,
  output logic              oPCSrc,
  output logic [DATA_W-1:0] obranch_target,
  mem_stage_if.master       dmem,
  output logic              oWB_valid,
  output logic              oWB_RegWrite,
  output logic              oWB_MemtoReg,
  output logic [DATA_W-1:0] oWB_read_data,
  output logic [DATA_W-1:0] oWB_ALU_result,
  output logic [REG_W-1:0]  oWB_write_reg,
  output logic              oMisaligned,
  output logic              oBusErr
);

  ex_mem_t em;
  logic    em_valid;
  logic    accept;
  logic    start;
  logic    done;
  logic    abort;
  logic    em_mem;
  logic    em_mis;
  logic    retire;

  assign accept = iValid & ~oStall;

  // Aligned memory ops enter ACCESS on their capture
  // edge, so the bus is busy the very next cycle.
  assign start = accept
               & (iSig_MemRead | iSig_MemWrite)
               & is_aligned(iALU_result);

  assign em_mem = em.mem_read | em.mem_write;
  assign em_mis = em_valid & em_mem
                & ~is_aligned(em.alu);
  assign retire = (em_valid & ~em_mem)
                | em_mis | done | abort;

  assign oPCSrc = em_valid & em.branch & em.zero;
  assign obranch_target = em.target;

  dmem_handshake #(
    .TIMEOUT(TIMEOUT)
  ) u_hs (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .we    (em.mem_write),
    .addr  (em.alu),
    .wdata (em.wdata),
    .done  (done),
    .abort (abort),
    .stall (oStall),
    .dmem  (dmem)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      em       <= '0;
      em_valid <= 1'b0;
    end else if (accept) begin
      em <= '{
        mem_read:   iSig_MemRead,
        mem_write:  iSig_MemWrite,
        branch:     iSig_Branch,
        reg_write:  iSig_RegWrite,
        mem_to_reg: iSig_MemtoReg,
        zero:       iALU_zero,
        target:     iadder_branch_result,
        alu:        iALU_result,
        wdata:      iregfile_read_2,
        wreg:       ireg_write_reg
      };
      em_valid <= 1'b1;
    end else if (~oStall | abort) begin
      em_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      oWB_valid      <= 1'b0;
      oWB_RegWrite   <= 1'b0;
      oWB_MemtoReg   <= 1'b0;
      oWB_read_data  <= '0;
      oWB_ALU_result <= '0;
      oWB_write_reg  <= '0;
      oMisaligned    <= 1'b0;
      oBusErr        <= 1'b0;
    end else begin
      oWB_valid <= retire;
      if (retire) begin
        oWB_RegWrite   <= em.reg_write
                        & ~em.mem_write
                        & ~em_mis & ~abort;
        oWB_MemtoReg   <= em.mem_to_reg;
        oWB_read_data  <= (done & em.mem_read)
                        ? dmem.idmem_rdata : '0;
        oWB_ALU_result <= em.alu;
        oWB_write_reg  <= em.wreg;
      end
      if (em_mis) oMisaligned <= 1'b1;
      if (abort)  oBusErr     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops, a
// scripted memory responder and a WB monitor.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        iValid = 1'b0;
  logic        iSig_MemRead = 1'b0;
  logic        iSig_MemWrite = 1'b0;
  logic        iSig_Branch = 1'b0;
  logic        iSig_RegWrite = 1'b0;
  logic        iSig_MemtoReg = 1'b0;
  logic [31:0] iadder_branch_result = '0;
  logic        iALU_zero = 1'b0;
  logic [31:0] iALU_result = '0;
  logic [31:0] iregfile_read_2 = '0;
  logic [4:0]  ireg_write_reg = '0;
  logic        oStall, oPCSrc;
  logic [31:0] obranch_target;
  logic        oWB_valid, oWB_RegWrite;
  logic        oWB_MemtoReg;
  logic [31:0] oWB_read_data, oWB_ALU_result;
  logic [4:0]  oWB_write_reg;
  logic        oMisaligned, oBusErr;
  logic        ack_r = 1'b0;
  logic [31:0] rdata_r = '0;

  always #5 clk = ~clk;

  mem_stage_if dmem_bus();
  assign dmem_bus.idmem_ack   = ack_r;
  assign dmem_bus.idmem_rdata = rdata_r;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .iValid(iValid),
    .iSig_MemRead(iSig_MemRead),
    .iSig_MemWrite(iSig_MemWrite),
    .iSig_Branch(iSig_Branch),
    .iSig_RegWrite(iSig_RegWrite),
    .iSig_MemtoReg(iSig_MemtoReg),
    .iadder_branch_result(iadder_branch_result),
    .iALU_zero(iALU_zero),
    .iALU_result(iALU_result),
    .iregfile_read_2(iregfile_read_2),
    .ireg_write_reg(ireg_write_reg),
    .oStall(oStall),
    .oPCSrc(oPCSrc),
    .obranch_target(obranch_target),
    .dmem(dmem_bus),
    .oWB_valid(oWB_valid),
    .oWB_RegWrite(oWB_RegWrite),
    .oWB_MemtoReg(oWB_MemtoReg),
    .oWB_read_data(oWB_read_data),
    .oWB_ALU_result(oWB_ALU_result),
    .oWB_write_reg(oWB_write_reg),
    .oMisaligned(oMisaligned),
    .oBusErr(oBusErr)
  );

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wreg;
    bit          chk_rd;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  exp_t        expq[$];
  req_t        reqq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_cycles = 0;
  int          pcsrc_cycles = 0;
  int          req_cycles = 0;
  int          n_req = 0;
  int          hold_err = 0;
  int          ack_lat = 0;
  logic [31:0] rdata_cfg = '0;
  logic [31:0] pc_tgt = '0;
  logic        late_ack = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic clr();
    stall_cycles = 0;
    pcsrc_cycles = 0;
    req_cycles = 0;
    n_req = 0;
    hold_err = 0;
    reqq.delete();
  endtask

  task automatic issue(
    input logic rd, input logic wr,
    input logic br, input logic rw,
    input logic mtr, input logic z,
    input logic [31:0] tgt,
    input logic [31:0] alu,
    input logic [31:0] wd,
    input logic [4:0] wreg);
    bit ok = 0;
    iValid = 1; iSig_MemRead = rd;
    iSig_MemWrite = wr; iSig_Branch = br;
    iSig_RegWrite = rw; iSig_MemtoReg = mtr;
    iALU_zero = z; iadder_branch_result = tgt;
    iALU_result = alu; iregfile_read_2 = wd;
    ireg_write_reg = wreg;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!oStall) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_accept: stalled 50 cycles");
    end
    @(posedge clk); #1;
    iValid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!dmem_bus.odmem_req && !oStall &&
          expq.size() == 0) begin
        ok = 1; break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: busy=%0d pend=%0d",
               dmem_bus.odmem_req, expq.size());
    end
    @(posedge clk); #1;
  endtask

  // Memory model: acks on the ack_lat-th request cycle
  initial begin
    int k = 0;
    logic [31:0] a0 = '0;
    forever begin
      @(posedge clk); #1;
      if (ack_r || !dmem_bus.odmem_req) k = 0;
      ack_r = 0;
      if (dmem_bus.odmem_req) begin
        k++;
        req_cycles++;
        if (k == 1) begin
          n_req++;
          a0 = dmem_bus.odmem_addr;
          reqq.push_back('{dmem_bus.odmem_we,
                           dmem_bus.odmem_addr,
                           dmem_bus.odmem_wdata});
        end else if (dmem_bus.odmem_addr != a0) begin
          hold_err++;
        end
        if (ack_lat != 0 && k == ack_lat) begin
          ack_r = 1;
          rdata_r = rdata_cfg;
        end
      end
      if (late_ack) ack_r = 1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        if (oStall) stall_cycles++;
        if (oPCSrc) begin
          pcsrc_cycles++;
          pc_tgt = obranch_target;
        end
        if (oWB_valid) begin
          if (expq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wb_unexpected: got alu=%h expected none",
                     oWB_ALU_result);
          end else begin
            e = expq.pop_front();
            chk("wb_regwrite", oWB_RegWrite, e.rw);
            chk("wb_memtoreg", oWB_MemtoReg, e.mtr);
            chk("wb_alu", oWB_ALU_result, e.alu);
            chk("wb_wreg", oWB_write_reg, e.wreg);
            if (e.chk_rd)
              chk("wb_rdata", oWB_read_data, e.rd);
          end
        end
      end
    end
  end

  always @(negedge clk)
    assert (!(iValid && iSig_Branch &&
              (iSig_MemRead || iSig_MemWrite)))
      else $error("branch marked as memory op");

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", oWB_valid, 0);
    chk("rst_stall", oStall, 0);
    chk("rst_req", dmem_bus.odmem_req, 0);
    chk("rst_mis", oMisaligned, 0);
    chk("rst_buserr", oBusErr, 0);
    chk("rst_pcsrc", oPCSrc, 0);
    chk("rst_wb_alu", oWB_ALU_result, 0);
    @(posedge clk); #1;
    rstn = 0;
    @(posedge clk); #1;

    // ALU op: two-edge latency, no bus traffic
    clr();
    expq.push_back('{1, 0, 0, 32'h10, 5, 1});
    issue(0, 0, 0, 1, 0, 0, 0, 32'h10, 0, 5);
    @(negedge clk);
    chk("alu_lat1", oWB_valid, 0);
    @(negedge clk);
    chk("alu_lat2", oWB_valid, 1);
    wait_idle();
    chk("alu_nreq", n_req, 0);

    // Load, ack on third request cycle
    clr();
    ack_lat = 3;
    rdata_cfg = 32'hDEADBEEF;
    expq.push_back('{1, 1, 32'hDEADBEEF,
                     32'h40, 7, 1});
    issue(1, 0, 0, 1, 1, 0, 0, 32'h40, 0, 7);
    wait_idle();
    chk("ld_req_cycles", req_cycles, 3);
    chk("ld_stall_cycles", stall_cycles, 2);
    chk("ld_nreq", n_req, 1);
    chk("ld_hold", hold_err, 0);
    chk("ld_addr", reqq[0].addr, 32'h40);
    chk("ld_we", reqq[0].we, 0);

    // Store then load back-to-back, 1-cycle acks
    clr();
    ack_lat = 1;
    rdata_cfg = 32'hCAFEF00D;
    expq.push_back('{0, 0, 0, 32'h44, 3, 1});
    issue(0, 1, 0, 1, 0, 0, 0, 32'h44,
          32'h1234, 3);
    expq.push_back('{1, 1, 32'hCAFEF00D,
                     32'h48, 9, 1});
    issue(1, 0, 0, 1, 1, 0, 0, 32'h48, 0, 9);
    wait_idle();
    chk("b2b_nreq", n_req, 2);
    chk("b2b_stall", stall_cycles, 0);
    chk("st_we", reqq[0].we, 1);
    chk("st_addr", reqq[0].addr, 32'h44);
    chk("st_wdata", reqq[0].wdata, 32'h1234);
    chk("ld2_we", reqq[1].we, 0);
    chk("ld2_addr", reqq[1].addr, 32'h48);

    // Misaligned load
    clr();
    expq.push_back('{0, 1, 0, 32'h42, 4, 0});
    issue(1, 0, 0, 1, 1, 0, 0, 32'h42, 0, 4);
    wait_idle();
    chk("mis_nreq", n_req, 0);
    chk("mis_flag", oMisaligned, 1);

    // Timeout abort and a late ack
    clr();
    ack_lat = 0;
    expq.push_back('{0, 1, 0, 32'h80, 6, 0});
    issue(1, 0, 0, 1, 1, 0, 0, 32'h80, 0, 6);
    wait_idle();
    chk("to_req_cycles", req_cycles, 4);
    chk("to_stall_cycles", stall_cycles, 4);
    chk("to_buserr", oBusErr, 1);
    chk("to_stall_low", oStall, 0);
    chk("to_nreq", n_req, 1);
    late_ack = 1;
    repeat (2) @(posedge clk);
    #1 late_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_nreq", n_req, 1);
    chk("late_stall", stall_cycles, 4);
    chk("late_pending", expq.size(), 0);

    // Branch taken / not taken
    clr();
    expq.push_back('{0, 0, 0, 0, 2, 0});
    issue(0, 0, 1, 0, 0, 1, 32'h100, 0, 0, 2);
    wait_idle();
    chk("br_taken_cycles", pcsrc_cycles, 1);
    chk("br_target", pc_tgt, 32'h100);
    clr();
    expq.push_back('{0, 0, 0, 0, 2, 0});
    issue(0, 0, 1, 0, 0, 0, 32'h100, 0, 0, 2);
    wait_idle();
    chk("br_not_taken", pcsrc_cycles, 0);
    chk("mis_sticky", oMisaligned, 1);

    // Reset in the middle of an access
    clr();
    ack_lat = 0;
    issue(1, 0, 0, 1, 1, 0, 0, 32'h90, 0, 8);
    @(negedge clk);
    chk("rst_pre_req", dmem_bus.odmem_req, 1);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rstm_req", dmem_bus.odmem_req, 0);
    chk("rstm_stall", oStall, 0);
    chk("rstm_wb_valid", oWB_valid, 0);
    chk("rstm_buserr", oBusErr, 0);
    chk("rstm_mis", oMisaligned, 0);
    @(posedge clk); #1;
    rstn = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("rstm_pending", expq.size(), 0);
    chk("rstm_nreq", n_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
